swap_scheduler: RTL and testbench

SWAP_SCHEDULER -- requirements
Module: swap_scheduler

---
 rtl/swap_scheduler.sv | 153 +++++++++++++++
 tb/tb_swap_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_scheduler.sv
// Round-robin swap arbiter driving a register-file swap port; optional SWAP_SKIP_SAME_EN skips A==B swaps.
// Latency: swap_o the cycle after grant, ack SWAP_CYCLES+2 cycles after the grant cycle (1 when skipped).
// Backpressure: req is level-held until ack and only sampled in IDLE; host writes are stalled while busy.
module swap_scheduler #(
    parameter int ADDR_WIDTH  = 7,
    parameter int NUM_REQ     = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_a,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_b,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          host_write_en,
    output logic                          write_en_o,
    output logic                          host_stall,
    output logic                          swap_o,
    output logic [ADDR_WIDTH-1:0]         address_A_o,
    output logic [ADDR_WIDTH-1:0]         address_B_o,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SWAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]      gnt_idx, gnt_idx_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_nxt;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_nxt;

    logic                  hi_vld, lo_vld, pick_vld;
    logic [IDX_W-1:0]      hi_idx, lo_idx, pick_idx;
    logic [ADDR_WIDTH-1:0] pick_a, pick_b;

    // Descending scan leaves the lowest matching index: lo_* over all requests,
    // hi_* over those at or above rr_ptr; hi wins, lo covers the wrap to 0.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_vld = 1'b1;
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
    end

    assign pick_vld = lo_vld;
    assign pick_idx = hi_vld ? hi_idx : lo_idx;

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_a = req_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_b = req_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
            cnt      <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt_idx  <= gnt_idx_nxt;
            cnt      <= cnt_nxt;
            addr_a_q <= addr_a_nxt;
            addr_b_q <= addr_b_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        gnt_idx_nxt = gnt_idx;
        cnt_nxt     = cnt;
        addr_a_nxt  = addr_a_q;
        addr_b_nxt  = addr_b_q;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_idx_nxt = pick_idx;
                    rr_ptr_nxt  = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
                    addr_a_nxt  = pick_a;
                    addr_b_nxt  = pick_b;
`ifdef SWAP_SKIP_SAME_EN
                    state_nxt   = (pick_a == pick_b) ? DONE : ISSUE;
`else
                    state_nxt   = ISSUE;
`endif
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
                cnt_nxt   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state == DONE) && (gnt_idx == IDX_W'(i));
        end
    end

    assign swap_o      = (state == ISSUE);
    assign busy        = (state == ISSUE) || (state == WAIT);
    assign host_stall  = busy;
    assign write_en_o  = host_write_en & ~busy;
    assign address_A_o = addr_a_q;
    assign address_B_o = addr_b_q;

endmodule

// File: tb/tb_swap_scheduler.sv
// Bench for swap_scheduler: directed vector table, hand sequences, then random traffic vs a timeline model.
module tb_swap_scheduler;

    localparam int AW = 7;
    localparam int NR = 4;
    localparam int SC = 3;
`ifdef SWAP_SKIP_SAME_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr_a;
    logic [NR*AW-1:0] req_addr_b;
    logic [NR-1:0]    ack;
    logic             host_write_en;
    logic             write_en_o;
    logic             host_stall;
    logic             swap_o;
    logic [AW-1:0]    address_A_o;
    logic [AW-1:0]    address_B_o;
    logic             busy;

    swap_scheduler #(.ADDR_WIDTH(AW), .NUM_REQ(NR), .SWAP_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .ack(ack),
        .host_write_en(host_write_en), .write_en_o(write_en_o),
        .host_stall(host_stall), .swap_o(swap_o),
        .address_A_o(address_A_o), .address_B_o(address_B_o), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] ra [NR];
    logic [AW-1:0] rb [NR];

    typedef struct {
        logic [NR-1:0] req;
        logic [AW-1:0] a0;
        logic [AW-1:0] b0;
        logic          hwe;
        logic          swap;
        logic          bsy;
        logic [NR-1:0] ack;
        logic          wen;
        logic [AW-1:0] oa;
        logic [AW-1:0] ob;
    } vec_t;

    vec_t tv [8];

    // timeline reference model: phase = cycles since the grant cycle, -1 when idle
    int            m_since, m_ptr, m_gnt, m_ack_at;
    bit            m_skip, rst_prev;
    logic [NR-1:0] p_req;
    logic [AW-1:0] p_a [NR];
    logic [AW-1:0] p_b [NR];
    logic [AW-1:0] m_a, m_b;
    bit            pend [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic e_swap, input logic e_busy,
                              input logic [NR-1:0] e_ack, input logic e_wen,
                              input logic [AW-1:0] e_a, input logic [AW-1:0] e_b);
        checks++;
        if ({swap_o, busy, host_stall, ack, write_en_o, address_A_o, address_B_o} !==
            {e_swap, e_busy, e_busy, e_ack, e_wen, e_a, e_b}) begin
            errors++;
            $display("FAIL %s: got swap=%b busy=%b stall=%b ack=%b wen=%b A=%0d B=%0d; expected swap=%b busy=%b stall=%b ack=%b wen=%b A=%0d B=%0d",
                     name, swap_o, busy, host_stall, ack, write_en_o, address_A_o, address_B_o,
                     e_swap, e_busy, e_busy, e_ack, e_wen, e_a, e_b);
        end
    endtask

    task automatic pack_addrs();
        for (int i = 0; i < NR; i++) begin
            req_addr_a[i*AW +: AW] = ra[i];
            req_addr_b[i*AW +: AW] = rb[i];
        end
    endtask

    // Leaves the bench at posedge+1 of cycle 0 with reset released.
    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        host_write_en = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic model_reset();
        m_since = -1;
        m_ptr = 0;
        m_gnt = 0;
        m_ack_at = 0;
        m_skip = 1'b0;
        m_a = '0;
        m_b = '0;
    endtask

    task automatic model_advance();
        int idx;
        if (m_since < 0) begin
            if (p_req != '0) begin
                idx = -1;
                for (int k = 0; k < NR; k++) begin
                    if (idx < 0 && p_req[(m_ptr + k) % NR]) idx = (m_ptr + k) % NR;
                end
                m_gnt = idx;
                m_ptr = (idx + 1) % NR;
                m_a = p_a[idx];
                m_b = p_b[idx];
                m_skip = SKIP && (m_a == m_b);
                m_ack_at = m_skip ? 1 : 2 + SC;
                m_since = 1;
            end
        end else begin
            m_since++;
            if (m_since > m_ack_at) m_since = -1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int ack_at;
        logic e_swap, e_busy;
        logic [NR-1:0] e_ack;

        tv[0] = '{4'b0001, 7'd5, 7'd9, 1'b1,  1'b0, 1'b0, 4'b0000, 1'b1, 7'd0, 7'd0};
        tv[1] = '{4'b0001, 7'd5, 7'd9, 1'b1,  1'b1, 1'b1, 4'b0000, 1'b0, 7'd5, 7'd9};
        tv[2] = '{4'b0001, 7'd5, 7'd9, 1'b1,  1'b0, 1'b1, 4'b0000, 1'b0, 7'd5, 7'd9};
        tv[3] = '{4'b0001, 7'd5, 7'd9, 1'b1,  1'b0, 1'b1, 4'b0000, 1'b0, 7'd5, 7'd9};
        tv[4] = '{4'b0001, 7'd5, 7'd9, 1'b1,  1'b0, 1'b1, 4'b0000, 1'b0, 7'd5, 7'd9};
        tv[5] = '{4'b0000, 7'd5, 7'd9, 1'b1,  1'b0, 1'b0, 4'b0001, 1'b1, 7'd5, 7'd9};
        tv[6] = '{4'b0000, 7'd0, 7'd0, 1'b1,  1'b0, 1'b0, 4'b0000, 1'b1, 7'd5, 7'd9};
        tv[7] = '{4'b0000, 7'd0, 7'd0, 1'b0,  1'b0, 1'b0, 4'b0000, 1'b0, 7'd5, 7'd9};

        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        pack_addrs();
        reset_n = 1'b0;
        req = '0;
        host_write_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_state", 1'b0, 1'b0, '0, 1'b0, '0, '0);
        reset_n = 1'b1;

        // single swap with host gating, one record per cycle
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            req = tv[i].req;
            ra[0] = tv[i].a0;
            rb[0] = tv[i].b0;
            pack_addrs();
            host_write_en = tv[i].hwe;
            #1;
            check_outs($sformatf("vec%0d", i), tv[i].swap, tv[i].bsy, tv[i].ack,
                       tv[i].wen, tv[i].oa, tv[i].ob);
        end

        // round-robin with all requests held high
        do_reset();
        for (int i = 0; i < NR; i++) begin
            ra[i] = AW'(10 + i);
            rb[i] = AW'(20 + i);
        end
        pack_addrs();
        req = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (ack == '0 && n < 20) begin
                @(posedge clk);
                #2;
                n++;
            end
            check($sformatf("rr_latency%0d", g), 64'(n), 64'(2 + SC));
            check($sformatf("rr_grant%0d", g), 64'(ack), 64'(1 << (g % NR)));
            check($sformatf("rr_addrA%0d", g), 64'(address_A_o), 64'(10 + g % NR));
            @(posedge clk);
            #2;
        end

        // reset in the middle of a swap, then a fresh request from requester 2
        do_reset();
        ra[0] = 7'd5;
        rb[0] = 7'd9;
        pack_addrs();
        req = 4'b0001;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1;
        check("mid_busy_before_reset", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check_outs("mid_reset_now", 1'b0, 1'b0, '0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check_outs("mid_reset_hold", 1'b0, 1'b0, '0, 1'b0, '0, '0);
        ra[2] = 7'd3;
        rb[2] = 7'd4;
        pack_addrs();
        req = 4'b0100;
        reset_n = 1'b1;
        for (int k = 1; k <= SC + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 2 + SC) req = '0;
            #1;
            check($sformatf("post_rst_swap%0d", k), 64'(swap_o), 64'(k == 1));
            check($sformatf("post_rst_ack%0d", k), 64'(ack), (k == 2 + SC) ? 64'(4'b0100) : 64'(0));
        end
        check("post_rst_addrA", 64'(address_A_o), 64'(3));

        // equal addresses
        do_reset();
        ra[0] = 7'd7;
        rb[0] = 7'd7;
        pack_addrs();
        req = 4'b0001;
        ack_at = SKIP ? 1 : 2 + SC;
        for (int k = 1; k <= SC + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == ack_at) req = '0;
            #1;
            e_swap = !SKIP && (k == 1);
            e_busy = !SKIP && (k >= 1) && (k <= 1 + SC);
            e_ack  = (k == ack_at) ? 4'b0001 : 4'b0000;
            check_outs($sformatf("eq_addr_k%0d", k), e_swap, e_busy, e_ack, 1'b0, 7'd7, 7'd7);
        end

        // random traffic against the timeline model
        do_reset();
        model_reset();
        rst_prev = 1'b0;
        p_req = '0;
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0;
            ra[i] = '0;
            rb[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (!rst_prev) model_advance();
            rst_prev = 1'b0;
            reset_n = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (pend[i]) begin
                    if ((m_since == m_ack_at && m_gnt == i) || $urandom_range(0, 49) == 0)
                        pend[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = AW'($urandom);
                    rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : AW'($urandom);
                end
                req[i] = pend[i];
            end
            pack_addrs();
            host_write_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                model_reset();
                rst_prev = 1'b1;
            end
            p_req = req;
            p_a = ra;
            p_b = rb;
            e_swap = !m_skip && (m_since == 1);
            e_busy = !m_skip && (m_since >= 1) && (m_since <= 1 + SC);
            e_ack  = (m_since >= 0 && m_since == m_ack_at) ? NR'(1) << m_gnt : '0;
            #1;
            check_outs($sformatf("rand_cyc%0d", cyc), e_swap, e_busy, e_ack,
                       host_write_en & ~e_busy, m_a, m_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
